// File: rtl/router_fsm_if.sv
// router_fsm_if
//   Bundles the ingress-control signals of the 1x3 router around router_fsm.
//   master : the surrounding datapath (input port, router_reg, synchronizer/FIFOs)
//            drives the status inputs and observes the state decodes.
//   slave  : router_fsm itself.
// Signals
//   pkt_valid          packet valid, header through last payload byte
//   data_in[1:0]       destination address field of the header byte
//   fifo_full          full flag of the currently addressed FIFO
//   fifo_empty_0..2    empty flags of the three output FIFOs
//   soft_reset_0..2    per-FIFO soft reset (read timeout)
//   parity_done        router_reg captured the parity byte
//   low_packet_valid   pkt_valid fell while the FIFO was full
//   detect_add .. busy state decodes and handshake outputs of the FSM
interface router_fsm_if #(
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic              fifo_empty_0;
  logic              fifo_empty_1;
  logic              fifo_empty_2;
  logic              soft_reset_0;
  logic              soft_reset_1;
  logic              soft_reset_2;
  logic              parity_done;
  logic              low_packet_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              full_state;
  logic              laf_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              busy;

  modport master (
    output pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// router_fsm
//   Ingress control FSM of the 1x3 router. Decodes the header address, waits
//   for the destination FIFO to drain, then steps header, payload and parity
//   bytes into router_reg, handling FIFO-full back-pressure and per-port soft
//   resets. All outputs are decoded from the state register only (Moore).
// Ports
//   i_clock  system clock, rising edge
//   i_reset  asynchronous, active-high reset
//   bus      router_fsm_if.slave: status inputs and state-decode outputs
//
// State table
//   state | meaning
//   DA    | DECODE_ADDRESS: idle, sample header address
//   WTE   | WAIT_TILL_EMPTY: destination FIFO still holds an older packet
//   LFD   | LOAD_FIRST_DATA: header byte into FIFO
//   LD    | LOAD_DATA: payload bytes written
//   FFS   | FIFO_FULL_STATE: destination full, hold the byte
//   LAF   | LOAD_AFTER_FULL: write the held byte once space frees up
//   LP    | LOAD_PARITY: parity byte written
//   CPE   | CHECK_PARITY_ERROR: router_reg compares parity
module router_fsm #(
  parameter int              ADDR_W   = 2,
  parameter logic [ADDR_W-1:0] BAD_ADDR = 2'b11
) (
  input  logic         i_clock,
  input  logic         i_reset,
  router_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_DA  = 3'd0,
    S_WTE = 3'd1,
    S_LFD = 3'd2,
    S_LD  = 3'd3,
    S_FFS = 3'd4,
    S_LAF = 3'd5,
    S_LP  = 3'd6,
    S_CPE = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;

  // Padded to four entries so the reserved address indexes a constant 0
  // instead of falling off the end of the vector.
  logic [3:0]        w_empty;
  logic [3:0]        w_soft;
  logic              w_hdr_ok;

  assign w_empty  = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign w_soft   = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign w_hdr_ok = bus.pkt_valid && (bus.data_in != BAD_ADDR);

  // State register and latched destination address.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_DA;
      r_addr  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DA && bus.pkt_valid) begin
        r_addr <= bus.data_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_DA: begin
        if (w_hdr_ok) begin
          w_next_state = w_empty[bus.data_in] ? S_LFD : S_WTE;
        end
      end
      S_WTE: begin
        if (w_empty[r_addr]) begin
          w_next_state = S_LFD;
        end
      end
      S_LFD: begin
        w_next_state = S_LD;
      end
      S_LD: begin
        if (bus.fifo_full) begin
          w_next_state = S_FFS;
        end else if (!bus.pkt_valid) begin
          w_next_state = S_LP;
        end
      end
      S_FFS: begin
        if (!bus.fifo_full) begin
          w_next_state = S_LAF;
        end
      end
      S_LAF: begin
        if (bus.parity_done) begin
          w_next_state = S_DA;
        end else if (bus.low_packet_valid) begin
          w_next_state = S_LP;
        end else begin
          w_next_state = S_LD;
        end
      end
      S_LP: begin
        w_next_state = S_CPE;
      end
      S_CPE: begin
        w_next_state = bus.fifo_full ? S_FFS : S_DA;
      end
      default: begin
        w_next_state = S_DA;
      end
    endcase

    // A soft reset of the port currently being served aborts the packet from
    // any state; soft resets of the other ports do not concern this packet.
    if (w_soft[r_addr]) begin
      w_next_state = S_DA;
    end
  end

  // Output decode, from the state register only.
  always_comb begin
    bus.detect_add    = (r_state == S_DA);
    bus.lfd_state     = (r_state == S_LFD);
    bus.ld_state      = (r_state == S_LD);
    bus.full_state    = (r_state == S_FFS);
    bus.laf_state     = (r_state == S_LAF);
    bus.rst_int_reg   = (r_state == S_CPE);
    bus.write_enb_reg = (r_state == S_LD) || (r_state == S_LAF) || (r_state == S_LP);
    // Input may only advance while idle or streaming payload.
    bus.busy          = !((r_state == S_DA) || (r_state == S_LD));
  end

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_fsm_if bus ();

  router_fsm dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    bit       rst;
    bit       pv;
    bit [1:0] din;
    bit       full;
    bit [2:0] empty;
    bit [2:0] sr;
    bit       pd;
    bit       lpv;
  } stim_t;

  typedef enum int {M_DA, M_WTE, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE} mst_t;

  mst_t       m_st   = M_DA;
  int         m_addr = 0;
  logic [7:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;

  // Expected outputs {detect_add, lfd, ld, full, laf, rst_int_reg, wr, busy}
  // straight from the per-state output rules.
  function automatic logic [7:0] m_out(mst_t s);
    logic wr, bsy;
    wr  = (s inside {M_LD, M_LAF, M_LP});
    bsy = !(s inside {M_DA, M_LD});
    return {s == M_DA, s == M_LFD, s == M_LD, s == M_FFS, s == M_LAF, s == M_CPE, wr, bsy};
  endfunction

  function automatic void model_step(stim_t s);
    mst_t nxt;
    if (s.rst) begin
      m_st   = M_DA;
      m_addr = 0;
      return;
    end
    nxt = m_st;
    case (m_st)
      M_DA:  if (s.pv && s.din != 2'd3) nxt = s.empty[s.din] ? M_LFD : M_WTE;
      M_WTE: if (s.empty[m_addr]) nxt = M_LFD;
      M_LFD: nxt = M_LD;
      M_LD:  if (s.full) nxt = M_FFS; else if (!s.pv) nxt = M_LP;
      M_FFS: if (!s.full) nxt = M_LAF;
      M_LAF: nxt = s.pd ? M_DA : (s.lpv ? M_LP : M_LD);
      M_LP:  nxt = M_CPE;
      M_CPE: nxt = s.full ? M_FFS : M_DA;
      default: nxt = M_DA;
    endcase
    if (m_addr < 3 && s.sr[m_addr]) nxt = M_DA;
    if (m_st == M_DA && s.pv) m_addr = s.din;
    m_st = nxt;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.pv = 0; s.din = 0; s.full = 0; s.empty = 3'b111;
    s.sr = 0; s.pd = 0; s.lpv = 0;
    return s;
  endfunction

  // Inputs change just after the falling edge (right after the monitor has
  // sampled), the model advances on the rising edge and queues the outputs
  // the DUT must show at the next falling edge.
  task automatic apply(stim_t s);
    @(negedge clk);
    #1;
    rst                  = s.rst;
    bus.pkt_valid        = s.pv;
    bus.data_in          = s.din;
    bus.fifo_full        = s.full;
    bus.fifo_empty_0     = s.empty[0];
    bus.fifo_empty_1     = s.empty[1];
    bus.fifo_empty_2     = s.empty[2];
    bus.soft_reset_0     = s.sr[0];
    bus.soft_reset_1     = s.sr[1];
    bus.soft_reset_2     = s.sr[2];
    bus.parity_done      = s.pd;
    bus.low_packet_valid = s.lpv;
    @(posedge clk);
    model_step(s);
    exp_q.push_back(m_out(m_st));
  endtask

  // Monitor: the DUT presents a state decode every cycle.
  initial begin
    logic [7:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state,
               bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t {da,lfd,ld,ffs,laf,cpe,wr,busy} got=%b exp=%b",
                   $time, got, e);
        end
      end
    end
  end

  // Drive the DA header and LFD cycle for a packet to port a (FIFO empty).
  task automatic start_pkt(int a);
    stim_t s;
    s = idle(); s.pv = 1; s.din = 2'(a);
    apply(s);
    apply(s);
  endtask

  initial begin
    stim_t s;

    // Reset state.
    s = idle(); s.rst = 1;
    apply(s);
    apply(s);

    // Packet to port 2: header, 3 payload bytes, parity.
    start_pkt(2);
    s = idle(); s.pv = 1; s.din = 2;
    apply(s); apply(s);
    s.pv = 0;
    apply(s); apply(s); apply(s); apply(s);

    // Port 1 busy for 5 cycles before it drains.
    s = idle(); s.pv = 1; s.din = 1; s.empty = 3'b101;
    apply(s);
    for (int i = 0; i < 4; i++) apply(s);
    s.empty = 3'b111;
    apply(s); apply(s);

    // Full for 3 cycles during LD, then LAF back to LD, then end of packet.
    s = idle(); s.pv = 1; s.din = 1; s.full = 1;
    apply(s); apply(s); apply(s);
    s.full = 0;
    apply(s); apply(s); apply(s);
    s.pv = 0;
    apply(s); apply(s); apply(s);

    // pkt_valid falls while full: LAF -> LP -> CPE -> DA.
    start_pkt(0);
    s = idle(); s.full = 1;
    apply(s);
    s.full = 0; s.lpv = 1;
    apply(s); apply(s); apply(s); apply(s); apply(s);

    // parity_done in LAF: straight back to DA.
    start_pkt(0);
    s = idle(); s.pv = 1; s.full = 1;
    apply(s);
    s.full = 0;
    apply(s);
    s.pd = 1;
    apply(s); apply(s);

    // Reserved address never accepted.
    s = idle(); s.pv = 1; s.din = 3;
    apply(s); apply(s); apply(s);

    // Soft reset of another port ignored, of the addressed port aborts.
    start_pkt(2);
    s = idle(); s.pv = 1; s.sr = 3'b001;
    apply(s); apply(s);
    s.sr = 3'b100;
    apply(s);
    s = idle();
    apply(s);

    // Asynchronous reset mid-LD.
    start_pkt(1);
    s = idle(); s.pv = 1;
    apply(s);
    s.rst = 1;
    apply(s);
    s = idle();
    apply(s); apply(s);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(0, 199) == 0);
      s.pv    = ($urandom_range(0, 4) != 0);
      s.din   = 2'($urandom_range(0, 3));
      s.full  = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        s.empty[k] = ($urandom_range(0, 9) < 7);
        s.sr[k]    = ($urandom_range(0, 39) == 0);
      end
      s.pd    = ($urandom_range(0, 3) == 0);
      s.lpv   = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
